// File: rtl/flick_pkg.sv
// flick_pkg: shared state encoding and default timing constants for the flick conditioner
package flick_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } flick_state_t;
  localparam int FLICK_DEBOUNCE_DEF = 16;
  localparam int FLICK_LONG_DEF = 1000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic reset-to-0 two-flop synchronizer for asynchronous inputs
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two back-to-back flops give a metastable first stage a full cycle to settle
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/flick_conditioner.sv
// flick_conditioner: debounces btn_raw into a clean flick level with rise/fall pulses; long-press pulse under FLICK_LONG_PRESS_EN
module flick_conditioner
  import flick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = FLICK_DEBOUNCE_DEF,
  parameter int LONG_CYCLES = FLICK_LONG_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       flick,
  output logic       flick_rise,
  output logic       flick_fall,
  output logic       long_press,
  output logic [1:0] state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync;
  flick_state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic flick_n, rise_n, fall_n;
  sync_2ff #(.W(1)) u_sync (.clk(clk), .reset(reset), .d(btn_raw), .q(sync));
  // a level change is accepted only after DEBOUNCE_CYCLES matching samples; pulses fire on acceptance only
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    flick_n = flick;
    rise_n = 1'b0;
    fall_n = 1'b0;
    case (st)
      LOW:
        if (sync) begin
          st_n = WAIT_HIGH;
          cnt_n = CW'(1);
        end
      WAIT_HIGH:
        if (!sync) begin
          st_n = LOW;
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          st_n = HIGH;
          cnt_n = '0;
          flick_n = 1'b1;
          rise_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      HIGH:
        if (!sync) begin
          st_n = WAIT_LOW;
          cnt_n = CW'(1);
        end
      WAIT_LOW:
        if (sync) begin
          st_n = HIGH;
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          st_n = LOW;
          cnt_n = '0;
          flick_n = 1'b0;
          fall_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: st_n = LOW;
    endcase
  end
  // state, debounce counter and registered level/pulse outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= LOW;
      cnt <= '0;
      flick <= 1'b0;
      flick_rise <= 1'b0;
      flick_fall <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      flick <= flick_n;
      flick_rise <= rise_n;
      flick_fall <= fall_n;
    end
  assign state = st;
`ifdef FLICK_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
  logic [HW-1:0] hold;
  logic grow;
  assign grow = (st == HIGH) && sync;
  // press duration saturates so long_press fires once per accepted press
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold <= '0;
      long_press <= 1'b0;
    end else begin
      hold <= rise_n ? '0 : (grow && hold != HOLD_MAX) ? hold + 1'b1 : hold;
      long_press <= grow && hold == HOLD_FIRE;
    end
`else
  logic unused_long;
  assign unused_long = ^LONG_CYCLES;
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_flick_conditioner.sv
// tb_flick_conditioner: directed plus randomized checks of flick_conditioner against a sample-history model
module tb_flick_conditioner;
  localparam int D = 4;
  localparam int L = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic flick, flick_rise, flick_fall, long_press;
  logic [1:0] state;
  int n_cmp = 0;
  int n_bad = 0;

  flick_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .flick(flick),
    .flick_rise(flick_rise), .flick_fall(flick_fall),
    .long_press(long_press), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hist[i] holds btn_raw as sampled i+1 edges ago; the conditioner acts on hist[1]
  bit hist [0:D+1];
  bit m_flick, m_rise, m_fall, m_long;
  bit [1:0] m_state;
  int hold_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (hist[i]) hist[i] = 1'b0;
      m_flick = 0; m_rise = 0; m_fall = 0; m_long = 0; m_state = 0; hold_m = 0;
    end else begin
      bit s, all_new;
      s = hist[1];
      all_new = 1'b1;
      for (int i = 1; i <= D; i++) if (hist[i] == m_flick) all_new = 1'b0;
      m_rise = 0; m_fall = 0; m_long = 0;
      if (m_flick && hist[2] && s && hold_m < L) begin
        hold_m++;
`ifdef FLICK_LONG_PRESS_EN
        m_long = (hold_m == L);
`endif
      end
      if (all_new) begin
        m_flick = !m_flick;
        m_rise = m_flick;
        m_fall = !m_flick;
        hold_m = 0;
      end
      for (int i = D + 1; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = btn_raw;
      m_state = {m_flick, m_flick ^ s};
    end
  end

  always @(negedge clk) if (!reset) begin
    check("flick", flick, m_flick);
    check("flick_rise", flick_rise, m_rise);
    check("flick_fall", flick_fall, m_fall);
    check("long_press", long_press, m_long);
    check("state", state, m_state);
  end

  initial begin
    int falls, longs, long_edge, any;
    repeat (3) tick();
    check("reset_outputs", {flick, flick_rise, flick_fall, long_press, state}, 0);
    reset = 1'b0;
    btn_raw = 1'b1;
    falls = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      falls += flick_fall;
      if (e == 5) check("press_e5_flick", flick, 0);
      if (e == 6) begin
        check("press_e6_flick", flick, 1);
        check("press_e6_rise", flick_rise, 1);
        check("press_e6_state", state, 2);
      end
      if (e == 7) check("press_e7_rise", flick_rise, 0);
    end
    check("press_no_fall", falls, 0);
    btn_raw = 1'b0;
    tick();
    btn_raw = 1'b1;
    tick();
    btn_raw = 1'b0;
    falls = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      falls += flick_fall;
      if (e == 5) check("release_e5_flick", flick, 1);
      if (e == 6) begin
        check("release_e6_flick", flick, 0);
        check("release_e6_fall", flick_fall, 1);
      end
    end
    check("release_one_fall", falls, 1);
    repeat (8) tick();
    any = 0;
    for (int e = 0; e < 14; e++) begin
      btn_raw = (e < 4) ? ~e[0] : 1'b0;
      tick();
      any += flick + flick_rise + flick_fall + long_press;
    end
    check("bounce_quiet", any, 0);
    check("bounce_state", state, 0);
    btn_raw = 1'b1;
    longs = 0;
    long_edge = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (long_press) begin
        longs++;
        if (long_edge == 0) long_edge = e;
      end
    end
    btn_raw = 1'b0;
    repeat (12) begin
      tick();
      longs += long_press;
    end
`ifdef FLICK_LONG_PRESS_EN
    check("long_count", longs, 1);
    check("long_edge", long_edge, 16);
`else
    check("long_count", longs, 0);
`endif
    repeat (4) tick();
    btn_raw = 1'b1;
    repeat (3) tick();
    check("mid_state", state, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", {flick, flick_rise, flick_fall, long_press, state}, 0);
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check("requal_e5_flick", flick, 0);
      if (e == 6) begin
        check("requal_e6_flick", flick, 1);
        check("requal_e6_rise", flick_rise, 1);
      end
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      btn_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) tick();
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
